move_replay: RTL

Inline recorder/replayer for the game's action-button pulses, sitting between the four debounced action-button flag outputs and the game-logic `act_flag` input. In normal play it forwards each single-button pulse with one cycle of latency and logs the move in a small buffer. On request it reads the log back and regenerates the same sequence as paced one-cycle pulses toward the game logic. This lets a game be replayed from a reset board.

---
 rtl/game_pkg.sv | 35 +++
 rtl/move_log.sv | 25 ++
 rtl/move_replay.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared action codes, replay FSM states and action code/flag conversion helpers.
package game_pkg;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_DOWN  = 2'd1;
    localparam logic [1:0] ACT_LEFT  = 2'd2;
    localparam logic [1:0] ACT_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } replay_state_t;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] flag);
        logic [1:0] code;
        code = ACT_UP;
        case (flag)
            4'b0010: code = ACT_DOWN;
            4'b0100: code = ACT_LEFT;
            4'b1000: code = ACT_RIGHT;
            default: code = ACT_UP;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot(input logic [3:0] flag);
        return (flag != 4'b0000) && ((flag & (flag - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/move_log.sv
// DEPTH x 2-bit move store: registered write port, combinational read port.
// No reset on contents; no backpressure (every write is accepted).
module move_log #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/move_replay.sv
// Records one-hot action pulses (1-cycle pass-through) and replays the log as pulses spaced GAP+1 apart.
// No backpressure: live presses are dropped while replaying and moves are dropped (ovf) once the log is full.
module move_replay
    import game_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GAP   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 act_flag,
    input  logic                       rec_clr,
    input  logic                       replay_go,
    input  logic                       replay_abort,
    output logic [3:0]                 act_out,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       ovf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP);

    replay_state_t state, state_nxt;
    logic [AW-1:0] rd, rd_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [CW-1:0] count_nxt;
    logic [3:0]    act_nxt;
    logic          ovf_nxt;
    logic          we;
    logic [1:0]    wdata;
    logic [1:0]    rdata;
    logic          press_ok;
    logic          start;
    logic          last;
    logic          abort;

    move_log #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_log (
        .clk   (clk),
        .we    (we),
        .waddr (count[AW-1:0]),
        .wdata (wdata),
        .raddr (rd),
        .rdata (rdata)
    );

    assign press_ok = is_onehot(act_flag);
    // A clear in the same cycle wins over a replay start so the FSM never walks an empty log.
    assign start    = replay_go && !rec_clr && (count != '0);
    assign last     = (CW'(rd) == count - CW'(1));
    assign abort    = replay_abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd      <= '0;
            gap_cnt <= '0;
            count   <= '0;
            full    <= 1'b0;
            ovf     <= 1'b0;
            act_out <= 4'b0000;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd      <= rd_nxt;
            gap_cnt <= gap_nxt;
            count   <= count_nxt;
            full    <= (count_nxt == DEPTH_C);
            ovf     <= ovf_nxt;
            act_out <= act_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (gap_cnt == GW'(1)) state_nxt = EMIT;
            EMIT:    state_nxt = last ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        act_nxt   = 4'b0000;
        count_nxt = count;
        ovf_nxt   = ovf;
        rd_nxt    = rd;
        gap_nxt   = gap_cnt;
        we        = 1'b0;
        wdata     = encode(act_flag);
        case (state)
            IDLE: begin
                if (press_ok) begin
                    act_nxt = act_flag;
                    if (!rec_clr) begin
                        if (count != DEPTH_C) begin
                            we        = 1'b1;
                            count_nxt = count + CW'(1);
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end
                if (rec_clr) begin
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end
                if (start) begin
                    rd_nxt  = '0;
                    gap_nxt = GAP_LD;
                end
            end
            // The pulse is launched on the final wait cycle so it is visible while in EMIT.
            WAIT: begin
                gap_nxt = gap_cnt - GW'(1);
                if (gap_cnt == GW'(1)) begin
                    act_nxt = onehot(rdata);
                end
            end
            EMIT: begin
                if (!last) begin
                    rd_nxt  = rd + AW'(1);
                    gap_nxt = GAP_LD;
                end
            end
            default: ;
        endcase
        if (abort) begin
            act_nxt = 4'b0000;
        end
    end

endmodule
